// File: rtl/sal_cmd_sched_pkg.sv
// Shared DRAM scheduler types: address/id fields, command and arbitration-class encodings,
// plus the counter load/decrement helpers used for inter-bank spacing.
package sal_cmd_sched_pkg;

  typedef logic [15:0] dram_ra_t;
  typedef logic [9:0]  dram_ca_t;
  typedef logic [3:0]  axi_id_t;
  typedef logic [7:0]  axi_len_t;
  typedef logic [7:0]  seq_num_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  // Lower value wins; also the row index into the per-class arbiter array.
  typedef enum logic [1:0] {
    CLS_REF = 2'd0,
    CLS_CAS = 2'd1,
    CLS_ACT = 2'd2,
    CLS_PRE = 2'd3
  } cls_t;

  localparam int CLS_NUM = 4;

  function automatic logic [7:0] t_load(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/sal_cmd_sched_if.sv
// Static DRAM timing parameters (in cycles) shared between the config source and the scheduler.
interface TIMING_IF;
  logic [7:0] t_rrd;
  logic [7:0] t_ccd;
  logic [7:0] t_wtr;
  logic [7:0] t_rtw;

  modport DRV (output t_rrd, t_ccd, t_wtr, t_rtw);
  modport MON (input  t_rrd, t_ccd, t_wtr, t_rtw);
endinterface

// File: rtl/sal_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after i_ptr.
module sal_rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt
);

  always_comb begin
    logic         found;
    logic [W-1:0] idx;
    o_gnt = '0;
    found = 1'b0;
    idx   = '0;
    // N is a power of two, so the W-bit add wraps modulo N.
    for (int i = 0; i < N; i++) begin
      idx = i_ptr + W'(i);
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// Inter-bank DRAM command scheduler: class-priority + round-robin arbitration under
// tRRD/tCCD/tWTR/tRTW spacing, one registered command per cycle toward the PHY.
module sal_cmd_sched
  import sal_cmd_sched_pkg::*;
#(
  parameter  int NUM_BANKS = 4,
  localparam int BW        = $clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      rst,
  TIMING_IF.MON                     timing_if,
  input  logic     [NUM_BANKS-1:0]  act_req_i,
  input  logic     [NUM_BANKS-1:0]  rd_req_i,
  input  logic     [NUM_BANKS-1:0]  wr_req_i,
  input  logic     [NUM_BANKS-1:0]  pre_req_i,
  input  logic     [NUM_BANKS-1:0]  ref_req_i,
  input  dram_ra_t [NUM_BANKS-1:0]  ra_i,
  input  dram_ca_t [NUM_BANKS-1:0]  ca_i,
  input  axi_id_t  [NUM_BANKS-1:0]  id_i,
  input  axi_len_t [NUM_BANKS-1:0]  len_i,
  input  seq_num_t [NUM_BANKS-1:0]  seq_num_i,
  output logic     [NUM_BANKS-1:0]  act_gnt_o,
  output logic     [NUM_BANKS-1:0]  rd_gnt_o,
  output logic     [NUM_BANKS-1:0]  wr_gnt_o,
  output logic     [NUM_BANKS-1:0]  pre_gnt_o,
  output logic     [NUM_BANKS-1:0]  ref_gnt_o,
  output logic                      cmd_valid_o,
  output cmd_t                      cmd_o,
  output logic     [BW-1:0]         ba_o,
  output dram_ra_t                  ra_o,
  output dram_ca_t                  ca_o,
  output axi_id_t                   id_o,
  output axi_len_t                  len_o,
  output seq_num_t                  seq_num_o
);

  logic [7:0]    r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;
  logic [BW-1:0] r_rr_ptr;

  // Only the highest class a bank asserts is visible; RD shadows WR within a bank.
  logic [NUM_BANKS-1:0] w_ref_v, w_rd_v, w_wr_v, w_act_v, w_pre_v;
  assign w_ref_v = ref_req_i;
  assign w_rd_v  = rd_req_i  & ~ref_req_i;
  assign w_wr_v  = wr_req_i  & ~rd_req_i & ~ref_req_i;
  assign w_act_v = act_req_i & ~(ref_req_i | rd_req_i | wr_req_i);
  assign w_pre_v = pre_req_i & ~(ref_req_i | rd_req_i | wr_req_i | act_req_i);

  logic w_rd_ok, w_wr_ok, w_act_ok;
  assign w_rd_ok  = (r_ccd_cnt == 8'd0) && (r_wtr_cnt == 8'd0);
  assign w_wr_ok  = (r_ccd_cnt == 8'd0) && (r_rtw_cnt == 8'd0);
  assign w_act_ok = (r_rrd_cnt == 8'd0);

  logic [CLS_NUM-1:0][NUM_BANKS-1:0] w_cls_req, w_cls_gnt;
  assign w_cls_req = {w_pre_v,
                      w_act_v & {NUM_BANKS{w_act_ok}},
                      (w_rd_v & {NUM_BANKS{w_rd_ok}}) | (w_wr_v & {NUM_BANKS{w_wr_ok}}),
                      w_ref_v};

  for (genvar c = 0; c < CLS_NUM; c++) begin : g_arb
    sal_rr_arbiter #(.N(NUM_BANKS)) u_arb (
      .i_req (w_cls_req[c]),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_cls_gnt[c])
    );
  end

  logic                 w_any;
  cls_t                 w_cls;
  logic [NUM_BANKS-1:0] w_sel;

  // Walk from lowest priority upward so the highest non-empty class is left standing.
  always_comb begin
    w_any = 1'b0;
    w_cls = CLS_PRE;
    w_sel = '0;
    for (int c = CLS_NUM-1; c >= 0; c--) begin
      if (|w_cls_gnt[c]) begin
        w_any = 1'b1;
        w_cls = cls_t'(c[1:0]);
        w_sel = w_cls_gnt[c];
      end
    end
  end

  logic          w_grant;
  cmd_t          w_cmd;
  logic [BW-1:0] w_bank;
  assign w_grant = w_any & ~rst;

  always_comb begin
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    w_cmd     = CMD_NOP;
    w_bank    = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (w_sel[b]) w_bank = BW'(b);
    if (w_grant) begin
      case (w_cls)
        CLS_REF: begin
          ref_gnt_o = w_sel;
          w_cmd     = CMD_REF;
        end
        CLS_CAS: begin
          rd_gnt_o = w_sel & w_rd_v;
          wr_gnt_o = w_sel & w_wr_v;
          w_cmd    = (|(w_sel & w_rd_v)) ? CMD_RD : CMD_WR;
        end
        CLS_ACT: begin
          act_gnt_o = w_sel;
          w_cmd     = CMD_ACT;
        end
        default: begin
          pre_gnt_o = w_sel;
          w_cmd     = CMD_PRE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrd_cnt   <= '0;
      r_ccd_cnt   <= '0;
      r_wtr_cnt   <= '0;
      r_rtw_cnt   <= '0;
      r_rr_ptr    <= '0;
      cmd_valid_o <= 1'b0;
      cmd_o       <= CMD_NOP;
      ba_o        <= '0;
      ra_o        <= '0;
      ca_o        <= '0;
      id_o        <= '0;
      len_o       <= '0;
      seq_num_o   <= '0;
    end else begin
      r_rrd_cnt <= (w_cmd == CMD_ACT) ? t_load(timing_if.t_rrd) : sat_dec(r_rrd_cnt);
      r_ccd_cnt <= (w_cmd == CMD_RD || w_cmd == CMD_WR) ? t_load(timing_if.t_ccd)
                                                         : sat_dec(r_ccd_cnt);
      r_wtr_cnt <= (w_cmd == CMD_WR) ? t_load(timing_if.t_wtr) : sat_dec(r_wtr_cnt);
      r_rtw_cnt <= (w_cmd == CMD_RD) ? t_load(timing_if.t_rtw) : sat_dec(r_rtw_cnt);
      cmd_valid_o <= w_grant;
      cmd_o       <= w_cmd;
      // Address fields hold across idle cycles.
      if (w_grant) begin
        r_rr_ptr  <= w_bank + BW'(1);
        ba_o      <= w_bank;
        ra_o      <= ra_i[w_bank];
        ca_o      <= ca_i[w_bank];
        id_o      <= id_i[w_bank];
        len_o     <= len_i[w_bank];
        seq_num_o <= seq_num_i[w_bank];
      end
    end
  end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: directed timing/priority scenarios plus randomized traffic
// checked against a timestamp-based reference model of the scheduling rules.
module tb_sal_cmd_sched;
  import sal_cmd_sched_pkg::*;

  localparam int NB = 4;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  TIMING_IF tif();

  logic     [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  dram_ra_t [NB-1:0] ra;
  dram_ca_t [NB-1:0] ca;
  axi_id_t  [NB-1:0] id;
  axi_len_t [NB-1:0] len;
  seq_num_t [NB-1:0] seq;
  logic     [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic              cmd_valid;
  cmd_t              cmd;
  logic     [BW-1:0] ba;
  dram_ra_t          ra_q;
  dram_ca_t          ca_q;
  axi_id_t           id_q;
  axi_len_t          len_q;
  seq_num_t          seq_q;

  sal_cmd_sched #(.NUM_BANKS(NB)) dut (
    .clk(clk), .rst(rst), .timing_if(tif),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len), .seq_num_i(seq),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
    .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .ba_o(ba),
    .ra_o(ra_q), .ca_o(ca_q), .id_o(id_q), .len_o(len_q), .seq_num_o(seq_q)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: absolute cycle timestamps of the last grants, not countdowns.
  int tr_rrd, tr_ccd, tr_wtr, tr_rtw;
  int cyc, m_ptr, last_act, last_rd, last_wr;
  logic        e_valid;
  cmd_t        e_cmd;
  int          e_ba;
  logic [45:0] e_fields;
  bit          auto_drop;

  // Cycle at which the DUT was last seen granting each (kind, bank).
  int d_act[NB], d_rd[NB], d_wr[NB], d_pre[NB], d_ref[NB];
  logic [NB-1:0] s_act, s_rd, s_wr, s_pre, s_ref;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_pick(output cmd_t k, output int bk);
    int   best, rank, key, last_cas;
    cmd_t c;
    bit   ok;
    k = CMD_NOP; bk = 0; best = 1 << 20;
    last_cas = (last_rd > last_wr) ? last_rd : last_wr;
    for (int b = 0; b < NB; b++) begin
      ok = 1'b1; rank = 0; c = CMD_NOP;
      if (ref_req[b])      begin rank = 0; c = CMD_REF; end
      else if (rd_req[b])  begin rank = 1; c = CMD_RD;
        ok = (cyc >= last_cas + tr_ccd) && (cyc >= last_wr + tr_wtr); end
      else if (wr_req[b])  begin rank = 1; c = CMD_WR;
        ok = (cyc >= last_cas + tr_ccd) && (cyc >= last_rd + tr_rtw); end
      else if (act_req[b]) begin rank = 2; c = CMD_ACT; ok = (cyc >= last_act + tr_rrd); end
      else if (pre_req[b]) begin rank = 3; c = CMD_PRE; end
      else ok = 1'b0;
      key = rank * NB + ((b - m_ptr + NB) % NB);
      if (ok && key < best) begin best = key; k = c; bk = b; end
    end
  endtask

  task automatic step();
    cmd_t k;
    int   bk;
    logic [NB-1:0] e_act, e_rd, e_wr, e_pre, e_ref;
    #1;
    model_pick(k, bk);
    e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0; e_ref = '0;
    case (k)
      CMD_ACT: e_act[bk] = 1'b1;
      CMD_RD:  e_rd[bk]  = 1'b1;
      CMD_WR:  e_wr[bk]  = 1'b1;
      CMD_PRE: e_pre[bk] = 1'b1;
      CMD_REF: e_ref[bk] = 1'b1;
      default: ;
    endcase
    s_act = act_gnt; s_rd = rd_gnt; s_wr = wr_gnt; s_pre = pre_gnt; s_ref = ref_gnt;
    chk("grant", 64'({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}),
                 64'({e_act, e_rd, e_wr, e_pre, e_ref}));
    for (int b = 0; b < NB; b++) begin
      if (s_act[b]) d_act[b] = cyc;
      if (s_rd[b])  d_rd[b]  = cyc;
      if (s_wr[b])  d_wr[b]  = cyc;
      if (s_pre[b]) d_pre[b] = cyc;
      if (s_ref[b]) d_ref[b] = cyc;
    end
    @(posedge clk); #1;
    if (k != CMD_NOP) begin
      m_ptr = (bk + 1) % NB;
      if (k == CMD_ACT) last_act = cyc;
      if (k == CMD_RD)  last_rd  = cyc;
      if (k == CMD_WR)  last_wr  = cyc;
      e_valid  = 1'b1;
      e_cmd    = k;
      e_ba     = bk;
      e_fields = {ra[bk], ca[bk], id[bk], len[bk], seq[bk]};
    end else begin
      e_valid = 1'b0;
      e_cmd   = CMD_NOP;
    end
    if (auto_drop) begin
      act_req &= ~s_act; rd_req &= ~s_rd; wr_req &= ~s_wr;
      pre_req &= ~s_pre; ref_req &= ~s_ref;
    end
    cyc++;
    chk("cmd_valid", 64'(cmd_valid), 64'(e_valid));
    chk("cmd", 64'(cmd), 64'(e_cmd));
    chk("ba", 64'(ba), 64'(e_ba));
    chk("fields", 64'({ra_q, ca_q, id_q, len_q, seq_q}), 64'(e_fields));
  endtask

  task automatic do_reset(input int rrd, input int ccd, input int wtr, input int rtw);
    rst = 1'b1;
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    for (int b = 0; b < NB; b++) begin
      ra[b] = dram_ra_t'(16'h100 + b); ca[b] = dram_ca_t'(10'h20 + b);
      id[b] = axi_id_t'(b); len[b] = axi_len_t'(8'h10 + b); seq[b] = seq_num_t'(8'h40 + b);
      d_act[b] = -1; d_rd[b] = -1; d_wr[b] = -1; d_pre[b] = -1; d_ref[b] = -1;
    end
    tr_rrd = rrd; tr_ccd = ccd; tr_wtr = wtr; tr_rtw = rtw;
    tif.t_rrd = 8'(rrd); tif.t_ccd = 8'(ccd); tif.t_wtr = 8'(wtr); tif.t_rtw = 8'(rtw);
    auto_drop = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_cmd", 64'(cmd), 64'(CMD_NOP));
    chk("rst_outs", 64'({ba, ra_q, ca_q, id_q, len_q, seq_q}), 64'(0));
    cyc = 0; m_ptr = 0; last_act = -1000; last_rd = -1000; last_wr = -1000;
    e_valid = 1'b0; e_cmd = CMD_NOP; e_ba = 0; e_fields = '0;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Priority: REF > CAS > PRE on consecutive cycles.
    do_reset(0, 0, 0, 0);
    ref_req = 4'b0100; rd_req = 4'b0001; pre_req = 4'b0010;
    repeat (4) step();
    chk("prio_ref_b2", 64'(d_ref[2]), 64'(0));
    chk("prio_rd_b0",  64'(d_rd[0]),  64'(1));
    chk("prio_pre_b1", 64'(d_pre[1]), 64'(2));

    // Round-robin over banks with RD held everywhere.
    do_reset(0, 1, 0, 0);
    rd_req = '1; auto_drop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_order", 64'(s_rd), 64'(1 << (k % 4)));
    end

    // tWTR after a WR, and plain tCCD without one.
    do_reset(0, 2, 6, 0);
    wr_req = 4'b0010; rd_req = 4'b0100;
    repeat (8) step();
    chk("wtr_wr_b1", 64'(d_wr[1]), 64'(0));
    chk("wtr_rd_b2", 64'(d_rd[2]), 64'(6));
    do_reset(0, 2, 6, 0);
    rd_req = 4'b0101;
    repeat (4) step();
    chk("ccd_rd_b0", 64'(d_rd[0]), 64'(0));
    chk("ccd_rd_b2", 64'(d_rd[2]), 64'(2));

    // tRTW with ACT falling through while WR is blocked.
    do_reset(0, 0, 0, 5);
    rd_req = 4'b0001; wr_req = 4'b0010; act_req = 4'b0100;
    repeat (7) step();
    chk("rtw_rd_b0",  64'(d_rd[0]),  64'(0));
    chk("rtw_act_b2", 64'(d_act[2]), 64'(1));
    chk("rtw_wr_b1",  64'(d_wr[1]),  64'(5));

    // tRRD with PRE filling the gap.
    do_reset(3, 0, 0, 0);
    act_req = 4'b1001; pre_req = 4'b0010;
    repeat (5) step();
    chk("rrd_act_b0", 64'(d_act[0]), 64'(0));
    chk("rrd_pre_b1", 64'(d_pre[1]), 64'(1));
    chk("rrd_act_b3", 64'(d_act[3]), 64'(3));

    // Reset mid-burst with ccd pending: grants drop at once, spacing is forgotten.
    do_reset(0, 4, 0, 0);
    rd_req = '1; auto_drop = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 64'({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}), 64'(0));
    chk("midrst_valid", 64'(cmd_valid), 64'(0));
    do_reset(0, 4, 0, 0);
    rd_req = '1; auto_drop = 1'b0;
    step();
    chk("midrst_rd_b0", 64'(d_rd[0]), 64'(0));
    chk("midrst_cmd", 64'(cmd), 64'(CMD_RD));
    chk("midrst_ba", 64'(ba), 64'(0));

    // Randomized traffic and timing against the reference model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      auto_drop = 1'b0;
      repeat (150) begin
        act_req = NB'($urandom & $urandom);
        rd_req  = NB'($urandom & $urandom);
        wr_req  = NB'($urandom & $urandom);
        pre_req = NB'($urandom & $urandom);
        ref_req = NB'($urandom & $urandom & $urandom);
        for (int b = 0; b < NB; b++) begin
          ra[b] = dram_ra_t'($urandom); ca[b] = dram_ca_t'($urandom);
          id[b] = axi_id_t'($urandom);  len[b] = axi_len_t'($urandom);
          seq[b] = seq_num_t'($urandom);
        end
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sal_cmd_sched.md
# sal_cmd_sched

Inter-bank DRAM command scheduler sitting directly downstream of the per-bank controllers. Each cycle it collects ACT/RD/WR/PRE/REF requests from `NUM_BANKS` bank controllers, enforces the inter-bank and data-bus timing constraints (tRRD, tCCD, tWTR, tRTW), and grants at most one request. The granted command is registered onto a single command output toward the DDR PHY/command encoder. Per-bank constraints (tRCD, tRP, tRAS, tRFC) are enforced by the bank controllers, not here.

## Interface
- `NUM_BANKS`, default 4: number of bank controllers; must be a power of two, ≥2.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `timing_if`  TIMING_IF.MON  -  consumes `t_rrd`, `t_ccd`, `t_wtr`, `t_rtw`. Each is 8 bits, in cycles, and static while `rst` is low.
- `act_req_i`, `rd_req_i`, `wr_req_i`, `pre_req_i`, `ref_req_i`  in  NUM_BANKS  per-bank request vectors.
- `ra_i`  in  NUM_BANKS×dram_ra_t  per-bank row address.
- `ca_i`  in  NUM_BANKS×dram_ca_t  per-bank column address.
- `id_i`  in  NUM_BANKS×axi_id_t  per-bank transaction id.
- `len_i`  in  NUM_BANKS×axi_len_t  per-bank burst length.
- `seq_num_i`  in  NUM_BANKS×seq_num_t  per-bank sequence number.
- `act_gnt_o`, `rd_gnt_o`, `wr_gnt_o`, `pre_gnt_o`, `ref_gnt_o`  out  NUM_BANKS  one-hot grants, combinational, same cycle as the request.
- `cmd_valid_o`  out  1  registered command strobe.
- `cmd_o`  out  cmd_t  NOP/ACT/RD/WR/PRE/REF.
- `ba_o`  out  $clog2(NUM_BANKS)  bank address.
- `ra_o`, `ca_o`, `id_o`, `len_o`, `seq_num_o`  out  (matching types)  fields of the granted bank.

## Operation
- **Class priority:** REF > CAS (RD or WR) > ACT > PRE. The highest class containing at least one eligible request wins.
- **Within a class:** round-robin arbitration over banks starting at `rr_ptr`. RD and WR share the CAS class.
- **Eligibility:**
  - RD is eligible iff `ccd_cnt==0 && wtr_cnt==0`.
  - WR is eligible iff `ccd_cnt==0 && rtw_cnt==0`.
  - ACT is eligible iff `rrd_cnt==0`.
  - PRE and REF are always eligible.
- **Blocked requests:** a blocked request is not granted. A lower class may still be granted that cycle. For example, RD blocked by tWTR does not prevent an ACT.
- **Grant count:** exactly one grant bit, across all 5×NUM_BANKS bits, is asserted per cycle, or none.
- **Requester behaviour:** a bank controller holds its request until granted and drops it the cycle after grant. The scheduler does not check for this.
- **Multiple requests from one bank:** if a bank asserts several requests at once, only the highest class is considered.
- **On grant:** `rr_ptr <= (granted_bank + 1) mod NUM_BANKS`. A single pointer is shared by all classes.
- **Counter loads on grant:** each counter loads `max(t_x − 1, 0)`.
  - ACT loads `rrd_cnt`.
  - RD loads `ccd_cnt` and `rtw_cnt`.
  - WR loads `ccd_cnt` and `wtr_cnt`.
- **Counter decrement:** each counter decrements by 1 per cycle while non-zero and saturates at 0.
- **Load vs decrement:** a load in the same cycle as a decrement takes the load value.
- **Back-to-back:** a `t_x` value of 0 or 1 permits same-class commands in consecutive cycles.
- **Reset:**
  - All counters = 0, `rr_ptr` = 0.
  - `cmd_valid_o` = 0, `cmd_o` = NOP, all other outputs = 0.
  - Grants are forced to 0 while `rst` is high.
  - A reset mid-sequence discards pending spacing.

## Timing
- **Grant:** combinational from request and counter state, cycle N.
- **Command output:** `cmd_valid_o`/`cmd_o`/fields registered, visible cycle N+1. Latency is 1.
- **Idle cycle:** the registered output becomes NOP with `cmd_valid_o` = 0. Address fields hold their last value.
- **Spacing:** a counter loaded at cycle N gates the same-constraint command until cycle N + t_x. Example: `t_ccd` = 4, RD granted at cycle 10, next CAS earliest at cycle 14.
- **Throughput:** at most one command per cycle.

## Structure
- **Shared package** (same package as the `dram_ra_t`, `dram_ca_t`, `axi_id_t`, `axi_len_t`, `seq_num_t` typedefs):
  - `cmd_t` enum.
  - Class encoding.
- **Sub-module `sal_rr_arbiter`:**
  - Parameter N; inputs are the request vector and the start pointer; output is a one-hot grant.
  - Purely combinational.
  - Instantiated four times (REF, CAS, ACT, PRE); a priority mux then selects the winning class.
- **Registers in the top level:** counters, `rr_ptr`, and the output registers.

## Test plan
- **Reset:** assert `rst` mid-burst with `ccd_cnt` = 3 → all grants 0 immediately; after release, RD on bank 0 is granted in the first cycle; `cmd_o` = RD, `ba_o` = 0 on the next cycle.
- **Round-robin fairness:** `NUM_BANKS` = 4, RD held on all banks, `t_ccd` = 1 → grants in order b0, b1, b2, b3, b0, one per cycle.
- **tCCD / tWTR:** `t_ccd` = 2, `t_wtr` = 6. WR b1 at cycle 0, then RD b2 requested → RD granted at cycle 6. With no WR preceding, RD at cycle 2.
- **tRTW and class fall-through:** `t_rtw` = 5. RD b0 at cycle 0; WR b1 and ACT b2 pending → ACT b2 at cycle 1, WR b1 at cycle 5.
- **tRRD:** `t_rrd` = 3, ACT on b0 and b3 → b0 at cycle 0, b3 at cycle 3. PRE b1 pending in between → granted at cycle 1.
- **Priority:** REF b2, RD b0, PRE b1 all asserted in one cycle → REF b2 granted first, then RD b0, then PRE b1, on consecutive cycles.
